// File: rtl/seq_addsub_chunked_if.sv
// Bus bundle for seq_addsub_chunked: the start/operand request side and
// the busy/done/result response side of the chunked adder/subtractor.
interface seq_addsub_chunked_if #(
    parameter int BUS_WIDTH = 16
);
    logic                 start;
    logic [BUS_WIDTH-1:0] op1;
    logic [BUS_WIDTH-1:0] op2;
    logic                 cin;
    logic                 sub;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] sum;
    logic                 cout;
    logic                 ovfl;

    modport master (
        output start, op1, op2, cin, sub,
        input  busy, done, sum, cout, ovfl
    );

    modport slave (
        input  start, op1, op2, cin, sub,
        output busy, done, sum, cout, ovfl
    );
endinterface

// File: rtl/seq_addsub_chunked.sv
// Multi-cycle signed adder/subtractor. The effective addition
// A + (sub ? ~B : B) + (cin ^ sub) is resolved CHUNK_WIDTH bits per clock,
// LSB slice first, with the slice carry held in a register so that the
// combinational carry chain never exceeds one slice.
module seq_addsub_chunked #(
    parameter int BUS_WIDTH   = 16,
    parameter int CHUNK_WIDTH = 4,
    parameter int SATURATE    = 0
) (
    input logic                 clk_i,
    input logic                 rst_i,
    seq_addsub_chunked_if.slave bus
);

    localparam int NCHUNK = BUS_WIDTH / CHUNK_WIDTH;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [IDXW-1:0]      chunkIdx_q, chunkIdx_d;
    logic [BUS_WIDTH-1:0] opA_q, opA_d;
    logic [BUS_WIDTH-1:0] opB_q, opB_d;
    logic [BUS_WIDTH-1:0] part_q, part_d;
    logic                 carry_q, carry_d;
    logic [BUS_WIDTH-1:0] sum_q, sum_d;
    logic                 cout_q, cout_d;
    logic                 ovfl_q, ovfl_d;

    logic [31:0]            chunkBase;
    logic [CHUNK_WIDTH-1:0] aChunk;
    logic [CHUNK_WIDTH-1:0] bChunk;
    logic [CHUNK_WIDTH:0]   chunkSum;
    logic [BUS_WIDTH-1:0]   rawSum;
    logic [BUS_WIDTH-1:0]   satSum;
    logic                   rawOvfl;

    // Slice datapath: add the current slice of A and the (already inverted
    // for subtract) B plus the registered carry, and merge the slice result
    // into the partial sum. The partial sum is cleared on start, so each
    // slice position is still zero when its result is OR-ed in.
    always_comb begin
        chunkBase = 32'(chunkIdx_q) * 32'(CHUNK_WIDTH);
        aChunk    = CHUNK_WIDTH'(opA_q >> chunkBase);
        bChunk    = CHUNK_WIDTH'(opB_q >> chunkBase);
        chunkSum  = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};
        rawSum    = part_q | (BUS_WIDTH'(chunkSum[CHUNK_WIDTH-1:0]) << chunkBase);
        rawOvfl   = (opA_q[BUS_WIDTH-1] & opB_q[BUS_WIDTH-1] & ~rawSum[BUS_WIDTH-1])
                  | (~opA_q[BUS_WIDTH-1] & ~opB_q[BUS_WIDTH-1] & rawSum[BUS_WIDTH-1]);
        satSum    = opA_q[BUS_WIDTH-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                       : {1'b0, {(BUS_WIDTH-1){1'b1}}};
    end

    // Next-state logic: latch operands on an accepted start, step one slice
    // per RUN cycle, and publish sum/cout/ovfl only on the final slice so
    // intermediate slices never show on the result port.
    always_comb begin
        state_d    = state_q;
        chunkIdx_d = chunkIdx_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        part_d     = part_q;
        carry_d    = carry_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovfl_d     = ovfl_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    opA_d      = bus.op1;
                    opB_d      = bus.op2 ^ {BUS_WIDTH{bus.sub}};
                    carry_d    = bus.cin ^ bus.sub;
                    part_d     = '0;
                    chunkIdx_d = '0;
                    state_d    = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                part_d  = rawSum;
                carry_d = chunkSum[CHUNK_WIDTH];
                if (chunkIdx_q == LAST_IDX) begin
                    cout_d  = chunkSum[CHUNK_WIDTH];
                    ovfl_d  = rawOvfl;
                    sum_d   = ((SATURATE != 0) && rawOvfl) ? satSum : rawSum;
                    state_d = DONE;
                end else begin
                    chunkIdx_d = chunkIdx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    // and clears the published result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            chunkIdx_q <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            part_q     <= '0;
            carry_q    <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovfl_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chunkIdx_q <= chunkIdx_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            part_q     <= part_d;
            carry_q    <= carry_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovfl_q     <= ovfl_d;
        end
    end

    // Handshake outputs decode directly from the state register.
    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = (state_q == DONE);
        bus.sum  = sum_q;
        bus.cout = cout_q;
        bus.ovfl = ovfl_q;
    end

endmodule

// File: tb/tb_seq_addsub_chunked.sv
// Bench for seq_addsub_chunked: three instances (wrap, saturate, single
// slice) share one stimulus stream and are checked every cycle against a
// transaction-level arithmetic model, plus directed literal checks.
module tb_seq_addsub_chunked;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovfl;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stStart;
    logic [15:0] stOp1;
    logic [15:0] stOp2;
    logic        stCin;
    logic        stSub;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    seq_addsub_chunked_if #(.BUS_WIDTH(16)) bus0 ();
    seq_addsub_chunked_if #(.BUS_WIDTH(16)) bus1 ();
    seq_addsub_chunked_if #(.BUS_WIDTH(16)) bus2 ();

    assign bus0.start = stStart;
    assign bus0.op1   = stOp1;
    assign bus0.op2   = stOp2;
    assign bus0.cin   = stCin;
    assign bus0.sub   = stSub;
    assign bus1.start = stStart;
    assign bus1.op1   = stOp1;
    assign bus1.op2   = stOp2;
    assign bus1.cin   = stCin;
    assign bus1.sub   = stSub;
    assign bus2.start = stStart;
    assign bus2.op1   = stOp1;
    assign bus2.op2   = stOp2;
    assign bus2.cin   = stCin;
    assign bus2.sub   = stSub;

    seq_addsub_chunked #(.BUS_WIDTH(16), .CHUNK_WIDTH(4), .SATURATE(0)) dutWrap (
        .clk_i(clk), .rst_i(rst), .bus(bus0)
    );
    seq_addsub_chunked #(.BUS_WIDTH(16), .CHUNK_WIDTH(4), .SATURATE(1)) dutSat (
        .clk_i(clk), .rst_i(rst), .bus(bus1)
    );
    seq_addsub_chunked #(.BUS_WIDTH(16), .CHUNK_WIDTH(16), .SATURATE(0)) dutOne (
        .clk_i(clk), .rst_i(rst), .bus(bus2)
    );

    logic [19:0] dOut [3];
    assign dOut[0] = {bus0.busy, bus0.done, bus0.sum, bus0.cout, bus0.ovfl};
    assign dOut[1] = {bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.ovfl};
    assign dOut[2] = {bus2.busy, bus2.done, bus2.sum, bus2.cout, bus2.ovfl};

    // Plain signed arithmetic: true result range decides overflow and the
    // saturation direction; the 17-bit unsigned sum gives the carry out.
    function automatic res_t refCalc(input logic [15:0] a, input logic [15:0] b,
                                     input logic c, input logic s, input bit sat);
        logic [15:0] be;
        logic [16:0] full;
        int          ce;
        int          trueSum;
        res_t        r;
        be      = s ? ~b : b;
        ce      = (c ^ s) ? 1 : 0;
        full    = {1'b0, a} + {1'b0, be} + 17'(ce);
        trueSum = int'($signed(a)) + int'($signed(be)) + ce;
        r.cout  = full[16];
        r.ovfl  = (trueSum > 32767) || (trueSum < -32768);
        r.sum   = full[15:0];
        if (sat && r.ovfl) r.sum = (trueSum < 0) ? 16'h8000 : 16'h7FFF;
        return r;
    endfunction

    function automatic int cfgSlices(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    logic mBusy [3];
    logic mDone [3];
    res_t mRes  [3];
    res_t mPend [3];
    int   mRem  [3];

    // Transaction model: an accepted start books its result and the number
    // of slice cycles it needs; the result appears with a one-cycle done.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                mBusy[k] <= 1'b0;
                mDone[k] <= 1'b0;
                mRes[k]  <= '0;
                mRem[k]  <= 0;
            end else if (mBusy[k]) begin
                mRem[k] <= mRem[k] - 1;
                if (mRem[k] == 1) begin
                    mBusy[k] <= 1'b0;
                    mDone[k] <= 1'b1;
                    mRes[k]  <= mPend[k];
                end
            end else begin
                mDone[k] <= 1'b0;
                if (stStart) begin
                    mPend[k] <= refCalc(stOp1, stOp2, stCin, stSub, k == 1);
                    mBusy[k] <= 1'b1;
                    mRem[k]  <= cfgSlices(k);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic compareModel();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("model cfg%0d {busy,done,sum,cout,ovfl}", k),
                        32'(dOut[k]), 32'({mBusy[k], mDone[k], mRes[k]}));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareModel();
    endtask

    // Presents one start for a cycle, then scrambles the operand lines so a
    // late re-latch would be visible.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
        stOp1   = a;
        stOp2   = b;
        stCin   = c;
        stSub   = s;
        stStart = 1'b1;
        tick();
        stStart = 1'b0;
        stOp1   = 16'($urandom);
        stOp2   = 16'($urandom);
    endtask

    task automatic waitDone(output int n, output int busyCycles, output int oneLat);
        n          = 0;
        busyCycles = bus0.busy ? 1 : 0;
        oneLat     = bus2.done ? 0 : -1;
        while (!bus0.done && n < 40) begin
            tick();
            n++;
            if (bus0.busy) busyCycles++;
            if (oneLat < 0 && bus2.done) oneLat = n;
        end
        checkOutput("done seen", 32'(bus0.done), 32'd1);
    endtask

    function automatic logic [15:0] pickOp();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        int nb;
        int n1;
        int cnt;
        int gap;
        int mode;

        rst     = 1'b1;
        stStart = 1'b0;
        stOp1   = '0;
        stOp2   = '0;
        stCin   = 1'b0;
        stSub   = 1'b0;
        repeat (3) tick();
        checkOutput("reset state", 32'(dOut[0]), 32'd0);
        rst = 1'b0;
        tick();

        applyStimulus(16'h1234, 16'h0FFF, 1'b1, 1'b0);
        waitDone(n, nb, n1);
        checkOutput("t1 result", 32'(dOut[0][17:0]), 32'({16'h2234, 1'b0, 1'b0}));
        checkOutput("t1 latency", 32'(n), 32'd4);
        checkOutput("t1 busy cycles", 32'(nb), 32'd4);
        checkOutput("t1 nchunk1 latency", 32'(n1), 32'd1);
        checkOutput("t1 nchunk1 result", 32'(dOut[2][17:0]), 32'({16'h2234, 1'b0, 1'b0}));

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        waitDone(n, nb, n1);
        checkOutput("t1b result", 32'(dOut[0][17:0]), 32'({16'h0000, 1'b1, 1'b0}));

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        waitDone(n, nb, n1);
        checkOutput("t2 wrap result", 32'(dOut[0][17:0]), 32'({16'h8000, 1'b0, 1'b1}));
        checkOutput("t2 sat result", 32'(dOut[1][17:0]), 32'({16'h7FFF, 1'b0, 1'b1}));

        applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1);
        waitDone(n, nb, n1);
        checkOutput("t3 wrap result", 32'(dOut[0][17:0]), 32'({16'h7FFF, 1'b1, 1'b1}));
        checkOutput("t3 sat result", 32'(dOut[1][17:0]), 32'({16'h8000, 1'b1, 1'b1}));

        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
        waitDone(n, nb, n1);
        checkOutput("t4 result", 32'(dOut[0][17:0]), 32'({16'hFFFD, 1'b0, 1'b0}));

        tick();
        applyStimulus(16'h0123, 16'h0456, 1'b0, 1'b0);
        stOp1   = 16'h1111;
        stOp2   = 16'h1111;
        stStart = 1'b1;
        tick();
        stStart = 1'b0;
        waitDone(n, nb, n1);
        checkOutput("t5 ignored start result", 32'(dOut[0][17:0]), 32'({16'h0579, 1'b0, 1'b0}));
        checkOutput("t5 latency", 32'(n), 32'd3);
        applyStimulus(16'h1111, 16'h1111, 1'b0, 1'b0);
        waitDone(n, nb, n1);
        checkOutput("t5 back-to-back gap", 32'(n + 1), 32'd5);
        checkOutput("t5 back-to-back result", 32'(dOut[0][17:0]), 32'({16'h2222, 1'b0, 1'b0}));
        tick();
        checkOutput("t5 single done pulse", 32'(bus0.done), 32'd0);

        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6 reset abort", 32'(dOut[0]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus0.done) cnt++;
        end
        checkOutput("t6 no done after abort", 32'(cnt), 32'd0);
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
        waitDone(n, nb, n1);
        checkOutput("t6 result", 32'(dOut[0][17:0]), 32'({16'h0003, 1'b0, 1'b0}));
        checkOutput("t6 latency", 32'(n), 32'd4);
        checkOutput("t6 nchunk1 latency", 32'(n1), 32'd1);

        for (int i = 0; i < 150; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            mode = $urandom_range(0, 19);
            applyStimulus(pickOp(), pickOp(), 1'($urandom), 1'($urandom));
            if (mode == 0) begin
                tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                if (mode < 5) begin
                    stStart = 1'b1;
                    tick();
                    stStart = 1'b0;
                end
                waitDone(n, nb, n1);
            end
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/seq_addsub_chunked.md
Name: seq_addsub_chunked

Overview:
Multi-cycle signed adder/subtractor for the float_point_adder datapath: resolves a BUS_WIDTH-bit add or subtract in CHUNK_WIDTH-bit slices, one slice per clock, rippling carry through a register.
- Generalises the combinational signed full adder with: subtract mode, registered carry-out/overflow flags, optional saturation, and a start/busy/done handshake.
- Trades latency for short carry chains on wide mantissa buses.

Parameters:
BUS_WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK_WIDTH.
CHUNK_WIDTH, 4, bits resolved per cycle; NCHUNK = BUS_WIDTH/CHUNK_WIDTH, NCHUNK >= 1.
SATURATE, 0, 1 = clamp sum to signed max/min on overflow; 0 = wrap.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; sampled only when busy=0
op1  in  BUS_WIDTH  signed operand A; sampled with accepted start
op2  in  BUS_WIDTH  signed operand B; sampled with accepted start
cin  in  1  carry-in (sub=0) or borrow-in (sub=1); sampled with accepted start
sub  in  1  0: op1+op2+cin; 1: op1-op2-cin; sampled with accepted start
busy  out  1  operation in progress
done  out  1  one-cycle pulse: result valid
sum  out  BUS_WIDTH  result, registered
cout  out  1  raw carry out of MSB of effective addition (sub: 1 = no borrow)
ovfl  out  1  signed overflow of effective addition

Behaviour:
- Reset: state IDLE; busy=0, done=0, sum=0, cout=0, ovfl=0; chunk index and carry cleared. Reset during RUN aborts the operation: no done pulse, outputs return to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE, start=1: latch A=op1, B=op2^{BUS_WIDTH{sub}}, carry=cin^sub; index=0; go RUN.
  - RUN: each cycle add A chunk[index] + B chunk[index] + carry, LSB chunk first. Store the partial sum and the new carry. At index=NCHUNK-1 go DONE, else index+1.
  - DONE: lasts exactly one cycle, then goes to IDLE unless a new start is accepted.
- Effective addition: A + B_eff + c_eff, with B_eff = sub ? ~op2 : op2 and c_eff = cin ^ sub.
- Latency: start sampled at edge E0. Chunk i is processed at edge E(i+1). At edge E(NCHUNK), sum/cout/ovfl are written and done=1. done is therefore high in the cycle following E(NCHUNK).
- Handshake:
  - busy=1 exactly while state=RUN.
  - done=1 exactly while state=DONE.
  - start while busy=1 is ignored; operands are not re-latched.
  - start in the DONE cycle is accepted (back-to-back): next done comes NCHUNK+1 cycles after the previous one.
- ovfl = (A[MSB] & B_eff[MSB] & ~r[MSB]) | (~A[MSB] & ~B_eff[MSB] & r[MSB]), where r = raw sum.
- cout = carry out of the final chunk; never affected by saturation.
- Saturation (SATURATE=1, ovfl=1): sum = A[MSB] ? {1,0...0} : {0,1...1}. ovfl is still reported as 1. With SATURATE=0, sum=r.
- sum/cout/ovfl hold their value from completion until the next completion (not cleared by start). Intermediate slices never appear on sum.
- NCHUNK=1 is legal: done 1 cycle after the start edge.

Test Plan (BUS_WIDTH=16, CHUNK_WIDTH=4 unless noted):
1. op1=0x1234, op2=0x0FFF, cin=1, sub=0 -> sum=0x2234, cout=0, ovfl=0; busy high 4 cycles; done 4 cycles after start edge. Then 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovfl=0.
2. 0x7FFF+0x0001, cin=0: SATURATE=0 -> sum=0x8000, ovfl=1, cout=0; SATURATE=1 -> sum=0x7FFF, ovfl=1.
3. sub=1, 0x8000-0x0001, cin=0 -> sum=0x7FFF, cout=1, ovfl=1; SATURATE=1 -> sum=0x8000.
4. sub=1, 0x0005-0x0007, cin=1 -> sum=0xFFFD, cout=0, ovfl=0.
5. Second start with 0x1111+0x1111 during RUN -> ignored, first result returned, single done pulse. Start during DONE -> accepted, next done exactly 5 cycles after the previous one.
6. rst=1 at the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0, no done pulse. A subsequent 0x0001+0x0002 -> 0x0003 with normal latency. Repeat with CHUNK_WIDTH=16 (NCHUNK=1) -> done 1 cycle after start.
